// File: rtl/alarm_pkg.sv
// ============================================================================
// Module      : alarm_pkg
// Description : Shared state encoding and sizing helper for the alarm
//               controller and its zone debouncers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  // Bits needed to hold any value in 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_ctrl_zone_debounce.sv
// ============================================================================
// Module      : zone_debounce
// Description : Single-zone conditioner: two-flop synchroniser followed by a
//               run-length counter. The debounced level flips only after
//               DEB_CYC consecutive synchronised samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zone_debounce
  import alarm_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic zone_i,
  output logic deb_o
);

  localparam int             CNT_W = cnt_width(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous sensor level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= zone_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounced level and run counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

`default_nettype wire

// File: rtl/alarm_ctrl.sv
// ============================================================================
// Module      : alarm_ctrl
// Description : Multi-zone intrusion alarm controller. Debounces the sensor
//               zones and sequences DISARMED / EXIT / ARMED / ENTRY / ALARM
//               with bypass, night mode, delayed and instant zones, and a
//               sticky record of the zones that caused the alarm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int                NZONES         = 5,
  parameter int                DEB_CYC        = 4,
  parameter int                EXIT_DLY       = 16,
  parameter int                ENTRY_DLY      = 12,
  parameter logic [NZONES-1:0] DELAY_ZONES    = 5'b00010,
  parameter logic [NZONES-1:0] INTERIOR_ZONES = 5'b10000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NZONES-1:0]  zone_in,
  input  logic [NZONES-1:0]  bypass,
  input  logic               night,
  input  logic               arm,
  input  logic               disarm,
  output logic [STATE_W-1:0] state,
  output logic               armed,
  output logic               siren,
  output logic               entry_warn,
  output logic               arm_fail,
  output logic [NZONES-1:0]  tripped
);

  localparam int               CNT_W      = cnt_width(max_int(EXIT_DLY, ENTRY_DLY));
  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DLY - 1);

  logic [NZONES-1:0] zone_deb;
  logic [NZONES-1:0] night_mask;
  logic [NZONES-1:0] arm_mask;
  logic [NZONES-1:0] active;
  logic [NZONES-1:0] arm_active;
  logic              inst_open;
  logic              delay_open;
  logic              arm_block;

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              night_q;
  logic              night_d;
  logic [NZONES-1:0] tripped_q;
  logic [NZONES-1:0] tripped_d;
  logic              armed_q;
  logic              armed_d;
  logic              siren_q;
  logic              siren_d;
  logic              warn_q;
  logic              warn_d;
  logic              arm_fail_q;
  logic              arm_fail_d;

  generate
    for (genvar g = 0; g < NZONES; g++) begin : g_zone
      zone_debounce #(
        .DEB_CYC (DEB_CYC)
      ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .zone_i (zone_in[g]),
        .deb_o  (zone_deb[g])
      );
    end
  endgenerate

  // Zone qualification. The session uses the latched night mode; the arming
  // check uses the night input instead, so it judges the mode being armed.
  always_comb begin
    night_mask = night_q ? INTERIOR_ZONES : '0;
    arm_mask   = night   ? INTERIOR_ZONES : '0;
    active     = zone_deb & ~bypass & ~night_mask;
    arm_active = zone_deb & ~bypass & ~arm_mask;
    inst_open  = |(active & ~DELAY_ZONES);
    delay_open = |(active & DELAY_ZONES);
    arm_block  = |(arm_active & ~DELAY_ZONES);
  end

  // Next-state, delay counter, night latch and trip record; disarm has top priority.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    night_d    = night_q;
    tripped_d  = tripped_q;
    arm_fail_d = 1'b0;

    if (disarm) begin
      state_d = ST_DISARMED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm) begin
            if (arm_block) begin
              arm_fail_d = 1'b1;
            end else begin
              state_d   = ST_EXIT;
              cnt_d     = '0;
              night_d   = night;
              tripped_d = '0;
            end
          end
        end
        ST_EXIT: begin
          if (cnt_q == EXIT_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ARMED: begin
          if (inst_open) begin
            state_d   = ST_ALARM;
            cnt_d     = '0;
            tripped_d = tripped_q | active;
          end else if (delay_open) begin
            state_d   = ST_ENTRY;
            cnt_d     = '0;
            tripped_d = tripped_q | active;
          end
        end
        ST_ENTRY: begin
          if (inst_open || (cnt_q == ENTRY_LAST)) begin
            state_d   = ST_ALARM;
            cnt_d     = '0;
            tripped_d = tripped_q | active;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ALARM: begin
          tripped_d = tripped_q | active;
        end
        default: begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
        end
      endcase
    end

    armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
    siren_d = (state_d == ST_ALARM);
    warn_d  = (state_d == ST_ENTRY);
  end

  // State and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISARMED;
      cnt_q      <= '0;
      night_q    <= 1'b0;
      tripped_q  <= '0;
      armed_q    <= 1'b0;
      siren_q    <= 1'b0;
      warn_q     <= 1'b0;
      arm_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      night_q    <= night_d;
      tripped_q  <= tripped_d;
      armed_q    <= armed_d;
      siren_q    <= siren_d;
      warn_q     <= warn_d;
      arm_fail_q <= arm_fail_d;
    end
  end

  assign state      = state_q;
  assign armed      = armed_q;
  assign siren      = siren_q;
  assign entry_warn = warn_q;
  assign arm_fail   = arm_fail_q;
  assign tripped    = tripped_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
// ============================================================================
// Module      : tb_alarm_ctrl
// Description : Directed and randomized bench for alarm_ctrl with a
//               timestamp/history based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_ctrl;

  localparam int         NZ  = 5;
  localparam int         DEB = 4;
  localparam int         EXD = 16;
  localparam int         ENT = 12;
  localparam logic [4:0] DLY = 5'b00010;
  localparam logic [4:0] INT = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] zone_in;
  logic [4:0] bypass;
  logic       night;
  logic       arm;
  logic       disarm;
  logic [2:0] state;
  logic       armed;
  logic       siren;
  logic       entry_warn;
  logic       arm_fail;
  logic [4:0] tripped;

  always #5 clk = ~clk;

  alarm_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .zone_in    (zone_in),
    .bypass     (bypass),
    .night      (night),
    .arm        (arm),
    .disarm     (disarm),
    .state      (state),
    .armed      (armed),
    .siren      (siren),
    .entry_warn (entry_warn),
    .arm_fail   (arm_fail),
    .tripped    (tripped)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode number, cycle timestamp of the last mode change,
  // raw/synchronised sample histories and the debounced view they imply.
  int         cyc;
  int         m_mode;
  int         m_since;
  logic       m_night;
  logic [4:0] m_trip;
  logic [4:0] m_deb;
  logic       m_fail;
  logic [4:0] rawq[$];
  logic [4:0] sq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_since = cyc;
    m_night = 1'b0;
    m_trip  = '0;
    m_deb   = '0;
    m_fail  = 1'b0;
    rawq    = {5'd0, 5'd0};
    sq      = {};
  endtask

  task automatic go(input int mode);
    m_mode  = mode;
    m_since = cyc;
  endtask

  task automatic model_step();
    logic [4:0] act;
    logic [4:0] inst;
    logic [4:0] arm_act;
    logic [4:0] synced;
    int         el;
    cyc++;
    el      = cyc - m_since;
    act     = m_deb & ~bypass & ~(m_night ? INT : 5'd0);
    inst    = act & ~DLY;
    arm_act = m_deb & ~bypass & ~(night ? INT : 5'd0) & ~DLY;
    m_fail  = 1'b0;
    if (disarm) begin
      if (m_mode != 0) go(0);
    end else begin
      case (m_mode)
        0: if (arm) begin
             if (arm_act != 0) m_fail = 1'b1;
             else begin go(1); m_night = night; m_trip = '0; end
           end
        1: if (el == EXD) go(2);
        2: if (act != 0) begin go((inst != 0) ? 4 : 3); m_trip |= act; end
        3: if (inst != 0 || el == ENT) begin go(4); m_trip |= act; end
        default: m_trip |= act;
      endcase
    end
    // Debounced level flips once the last DEB synchronised samples all disagree.
    synced = rawq.pop_front();
    rawq.push_back(zone_in);
    sq.push_back(synced);
    if (sq.size() > DEB) void'(sq.pop_front());
    if (sq.size() == DEB) begin
      for (int z = 0; z < NZ; z++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (sq[j][z] == m_deb[z]) all_diff = 1'b0;
        if (all_diff) m_deb[z] = ~m_deb[z];
      end
    end
  endtask

  task automatic check_outputs();
    chk("state",      32'(state),      32'(m_mode));
    chk("armed",      32'(armed),      32'(m_mode >= 2));
    chk("siren",      32'(siren),      32'(m_mode == 4));
    chk("entry_warn", 32'(entry_warn), 32'(m_mode == 3));
    chk("arm_fail",   32'(arm_fail),   32'(m_fail));
    chk("tripped",    32'(tripped),    32'(m_trip));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm = 1'b1; tick(); disarm = 1'b0;
  endtask

  initial begin
    cyc = 0;
    rst_n = 1'b0; zone_in = 5'b11111; bypass = '0; night = 1'b0; arm = 1'b0; disarm = 1'b0;
    model_reset();

    // 1. reset with every zone open
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    ticks(12);
    chk("t1_siren", 32'(siren), 32'd0);
    zone_in = '0;
    ticks(10);

    // 2. arm, exit delay, glitch rejection
    pulse_arm();
    chk("t2_exit", 32'(state), 32'd1);
    ticks(15);
    chk("t2_exit_end", 32'(state), 32'd1);
    tick();
    chk("t2_armed_st", 32'(state), 32'd2);
    chk("t2_armed", 32'(armed), 32'd1);
    zone_in[2] = 1'b1; ticks(3); zone_in[2] = 1'b0;
    ticks(10);
    chk("t2_glitch", 32'(state), 32'd2);

    // 3. delay zone -> entry, disarm; then let entry expire
    zone_in[1] = 1'b1;
    ticks(6);
    chk("t3_warn_early", 32'(entry_warn), 32'd0);
    tick();
    chk("t3_warn", 32'(entry_warn), 32'd1);
    chk("t3_trip", 32'(tripped), 32'b00010);
    ticks(4);
    pulse_disarm();
    chk("t3_disarm", 32'(state), 32'd0);
    chk("t3_no_siren", 32'(siren), 32'd0);
    zone_in = '0; ticks(10);
    pulse_arm(); ticks(16);
    zone_in[1] = 1'b1;
    ticks(7);
    chk("t3_entry", 32'(state), 32'd3);
    ticks(11);
    chk("t3_siren_early", 32'(siren), 32'd0);
    tick();
    chk("t3_siren", 32'(siren), 32'd1);
    pulse_disarm();
    zone_in = '0; ticks(10);

    // 4. night mode: interior ignored, instant zone alarms
    night = 1'b1; pulse_arm(); night = 1'b0;
    ticks(16);
    zone_in[4] = 1'b1; ticks(10);
    chk("t4_interior", 32'(state), 32'd2);
    zone_in[0] = 1'b1; ticks(7);
    chk("t4_alarm", 32'(state), 32'd4);
    chk("t4_trip", 32'(tripped), 32'b00001);

    // reset asserted mid-alarm takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_siren", 32'(siren), 32'd0);
    chk("mid_rst_trip", 32'(tripped), 32'd0);
    chk("mid_rst_armed", 32'(armed), 32'd0);
    model_reset();
    zone_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(10);

    // 5. open instant zone refuses arming; bypass allows it
    zone_in[3] = 1'b1; ticks(8);
    pulse_arm();
    chk("t5_fail", 32'(arm_fail), 32'd1);
    chk("t5_state", 32'(state), 32'd0);
    tick();
    chk("t5_fail_pulse", 32'(arm_fail), 32'd0);
    bypass[3] = 1'b1;
    pulse_arm();
    chk("t5_bypass_arm", 32'(state), 32'd1);
    pulse_disarm();
    zone_in = '0; bypass = '0; ticks(10);

    // 6. disarm priority
    arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
    chk("t6_arm_disarm", 32'(state), 32'd0);
    pulse_arm(); ticks(16);
    zone_in[0] = 1'b1; ticks(6);
    pulse_disarm();
    chk("t6_trip_disarm", 32'(state), 32'd0);
    chk("t6_siren", 32'(siren), 32'd0);
    zone_in = '0; ticks(10);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) zone_in = 5'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 63) == 0) bypass = 5'($urandom & $urandom);
      night  = 1'($urandom_range(0, 1));
      arm    = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 79) == 0);
      tick();
    end
    arm = 1'b0; disarm = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
